// File: rtl/fetch_unit.sv
// In-order instruction fetch: issues sequential requests, buffers returned words in a
// DEPTH-entry circular buffer and flushes on redirect, dropping responses to squashed requests.
module fetch_unit #(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int unsigned     DEPTH        = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   redirect_valid,
    input  logic [XLEN-1:0]        redirect_pc,
    output logic                   imem_req_valid,
    output logic [XLEN-1:0]        imem_req_addr,
    input  logic                   imem_req_ready,
    input  logic                   imem_rsp_valid,
    input  logic [31:0]            imem_rsp_data,
    output logic                   if_valid,
    output logic [XLEN-1:0]        if_pc,
    output logic [31:0]            if_instr,
    input  logic                   if_ready,
    output logic [$clog2(DEPTH):0] occupancy
);
    localparam int unsigned   AW     = $clog2(DEPTH);
    localparam int unsigned   CW     = AW + 1;
    localparam logic [CW-1:0] DepthC = CW'(DEPTH);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [AW-1:0]   head_q, head_d, tail_q, tail_d, fill_q, fill_d;
    logic [CW-1:0]   occ_q, occ_d, pend_q, pend_d, discard_q, discard_d;
    logic [CW:0]     disc_sum;

    logic [XLEN-1:0] buf_pc_q    [DEPTH];
    logic [31:0]     buf_instr_q [DEPTH];
    logic [DEPTH-1:0] buf_filled_q;

    logic accept, pop, rsp_fill, rsp_drop;
    logic unused_pc_bits;

    assign unused_pc_bits = ^redirect_pc[1:0];

    always_comb begin
        imem_req_valid = reset && !redirect_valid && (occ_q < DepthC);
        imem_req_addr  = fetch_pc_q;
        if_valid       = (occ_q != '0) && buf_filled_q[head_q];
        if_pc          = buf_pc_q[head_q];
        if_instr       = buf_instr_q[head_q];
        occupancy      = occ_q;
    end

    assign accept   = imem_req_valid && imem_req_ready;
    assign pop      = if_valid && if_ready;
    // Responses owed to squashed requests are consumed first, before any buffer fill.
    assign rsp_drop = imem_rsp_valid && (discard_q != '0);
    assign rsp_fill = imem_rsp_valid && (discard_q == '0) && (pend_q != '0);

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        head_d     = head_q;
        tail_d     = tail_q;
        fill_d     = fill_q;
        occ_d      = occ_q;
        pend_d     = pend_q;
        discard_d  = discard_q;
        disc_sum   = {1'b0, discard_q} + {1'b0, pend_q};
        if (imem_rsp_valid && (disc_sum != '0)) begin
            disc_sum = disc_sum - (CW + 1)'(1);
        end

        if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
            head_d     = '0;
            tail_d     = '0;
            fill_d     = '0;
            occ_d      = '0;
            pend_d     = '0;
            discard_d  = (disc_sum > {1'b0, DepthC}) ? DepthC : disc_sum[CW-1:0];
        end else begin
            if (accept) begin
                fetch_pc_d = fetch_pc_q + XLEN'(4);
                tail_d     = tail_q + AW'(1);
            end
            if (pop) begin
                head_d = head_q + AW'(1);
            end
            if (rsp_fill) begin
                fill_d = fill_q + AW'(1);
            end
            if (rsp_drop) begin
                discard_d = discard_q - CW'(1);
            end
            occ_d  = occ_q + CW'(accept) - CW'(pop);
            pend_d = pend_q + CW'(accept) - CW'(rsp_fill);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_pc_q   <= RESET_VECTOR;
            head_q       <= '0;
            tail_q       <= '0;
            fill_q       <= '0;
            occ_q        <= '0;
            pend_q       <= '0;
            discard_q    <= '0;
            buf_filled_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                buf_pc_q[i]    <= '0;
                buf_instr_q[i] <= '0;
            end
        end else begin
            fetch_pc_q <= fetch_pc_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            fill_q     <= fill_d;
            occ_q      <= occ_d;
            pend_q     <= pend_d;
            discard_q  <= discard_d;
            if (accept) begin
                buf_pc_q[tail_q]     <= fetch_pc_q;
                buf_filled_q[tail_q] <= 1'b0;
            end
            if (rsp_fill && !redirect_valid) begin
                buf_instr_q[fill_q]  <= imem_rsp_data;
                buf_filled_q[fill_q] <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with an in-order instruction memory model of configurable
// latency and optional ready toggling.
module tb_fetch_unit;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 4;

    logic            clk;
    logic            reset;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            imem_req_valid;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_req_ready;
    logic            imem_rsp_valid;
    logic [31:0]     imem_rsp_data;
    logic            if_valid;
    logic [XLEN-1:0] if_pc;
    logic [31:0]     if_instr;
    logic            if_ready;
    logic [2:0]      occupancy;

    fetch_unit #(
        .XLEN         (XLEN),
        .RESET_VECTOR (32'h0000_0000),
        .DEPTH        (DEPTH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_instr       (if_instr),
        .if_ready       (if_ready),
        .occupancy      (occupancy)
    );

    int          n_checks = 0;
    int          n_fails  = 0;
    int          cyc      = 0;
    int          lat      = 1;
    bit          toggle_ready = 1'b0;
    int          n_req    = 0;
    logic [31:0] last_req_addr = 32'h0;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;
    req_t mem_q[$];

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'hC0DE_0013;
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    // Memory: drives response/ready at negedge, records the request the next posedge accepts.
    initial begin
        req_t r;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                mem_q.delete();
                imem_rsp_valid = 1'b0;
            end else if (mem_q.size() > 0 && cyc >= mem_q[0].due) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = instr_of(mem_q[0].addr);
                void'(mem_q.pop_front());
            end else begin
                imem_rsp_valid = 1'b0;
            end
            imem_req_ready = toggle_ready ? !imem_req_ready : 1'b1;
            #3;
            if (reset && imem_req_valid && imem_req_ready) begin
                r.addr = imem_req_addr;
                r.due  = cyc + lat;
                mem_q.push_back(r);
                n_req++;
                last_req_addr = imem_req_addr;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Waits for the next head instruction (if_ready held high) and checks it.
    task automatic expect_next(input logic [31:0] pc);
        int waited = 0;
        while (!if_valid && waited < 50) begin
            tick();
            waited++;
        end
        check("wait_if_valid", {31'd0, if_valid}, 32'd1);
        check("if_pc", if_pc, pc);
        check("if_instr", if_instr, instr_of(pc));
        tick();
    endtask

    initial begin
        int base;
        int waited;
        reset          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        if_ready       = 1'b0;
        repeat (3) tick();

        check("rst_if_valid", {31'd0, if_valid}, 32'd0);
        check("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        check("rst_occupancy", 32'(occupancy), 32'd0);
        check("rst_if_pc", if_pc, 32'h0);
        check("rst_if_instr", if_instr, 32'h0);
        check("rst_req_addr", imem_req_addr, 32'h0);

        // Streaming: 1-cycle memory, decode always ready.
        reset    = 1'b1;
        if_ready = 1'b1;
        #1;
        check("first_req_valid", {31'd0, imem_req_valid}, 32'd1);
        check("first_req_addr", imem_req_addr, 32'h0);
        tick();
        check("fill_if_valid", {31'd0, if_valid}, 32'd0);
        check("fill_occupancy", 32'(occupancy), 32'd1);
        tick();
        for (int i = 0; i < 8; i++) begin
            check("stream_if_valid", {31'd0, if_valid}, 32'd1);
            check("stream_if_pc", if_pc, 32'(i) * 32'd4);
            check("stream_if_instr", if_instr, instr_of(32'(i) * 32'd4));
            tick();
        end
        check("stream_occupancy", 32'(occupancy), 32'd2);

        // Back-pressure: buffer fills to DEPTH, one pop frees one slot.
        reset    = 1'b0;
        if_ready = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        base  = n_req;
        repeat (8) tick();
        check("bp_occupancy", 32'(occupancy), 32'd4);
        check("bp_req_valid", {31'd0, imem_req_valid}, 32'd0);
        check("bp_req_count", 32'(n_req - base), 32'd4);
        check("bp_last_addr", last_req_addr, 32'hC);
        check("bp_if_valid", {31'd0, if_valid}, 32'd1);
        check("bp_if_pc", if_pc, 32'h0);
        if_ready = 1'b1;
        tick();
        if_ready = 1'b0;
        #1;
        check("pop_occupancy", 32'(occupancy), 32'd3);
        check("pop_if_pc", if_pc, 32'h4);
        check("pop_req_valid", {31'd0, imem_req_valid}, 32'd1);
        check("pop_req_addr", imem_req_addr, 32'h10);
        tick();
        check("refill_occupancy", 32'(occupancy), 32'd4);
        check("refill_req_count", 32'(n_req - base), 32'd5);
        check("refill_last_addr", last_req_addr, 32'h10);
        check("refill_req_valid", {31'd0, imem_req_valid}, 32'd0);

        // Redirect with two unanswered requests (3-cycle memory).
        reset = 1'b0;
        tick();
        tick();
        lat   = 3;
        reset = 1'b1;
        tick();
        tick();
        check("rd_pre_occupancy", 32'(occupancy), 32'd2);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h103;
        #1;
        check("rd_req_valid_low", {31'd0, imem_req_valid}, 32'd0);
        tick();
        redirect_valid = 1'b0;
        if_ready       = 1'b1;
        #1;
        check("rd_occupancy", 32'(occupancy), 32'd0);
        check("rd_if_valid", {31'd0, if_valid}, 32'd0);
        check("rd_req_valid", {31'd0, imem_req_valid}, 32'd1);
        check("rd_req_addr", imem_req_addr, 32'h100);
        tick();
        check("rd_drop_occupancy", 32'(occupancy), 32'd1);
        check("rd_drop_if_valid", {31'd0, if_valid}, 32'd0);
        expect_next(32'h100);
        expect_next(32'h104);
        expect_next(32'h108);

        // Back-to-back redirects; last one lands at the top of the address space.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h400;
        tick();
        redirect_pc = 32'hFFFF_FFFE;
        tick();
        redirect_valid = 1'b0;
        #1;
        check("wrap_req_addr", imem_req_addr, 32'hFFFF_FFFC);
        check("wrap_req_valid", {31'd0, imem_req_valid}, 32'd1);
        check("wrap_if_valid", {31'd0, if_valid}, 32'd0);
        tick();
        check("wrap_next_addr", imem_req_addr, 32'h0);
        expect_next(32'hFFFF_FFFC);
        expect_next(32'h0);
        expect_next(32'h4);

        // Ready toggling each cycle with 3-cycle latency over 100 instructions.
        toggle_ready   = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h2000;
        tick();
        redirect_valid = 1'b0;
        for (int i = 0; i < 100; i++) begin
            expect_next(32'h2000 + 32'(i) * 32'd4);
        end

        // One-cycle reset pulse with three entries allocated.
        toggle_ready   = 1'b0;
        lat            = 1;
        if_ready       = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h3000;
        tick();
        redirect_valid = 1'b0;
        waited = 0;
        while (occupancy != 3'd3 && waited < 20) begin
            tick();
            waited++;
        end
        check("pulse_pre_occupancy", 32'(occupancy), 32'd3);
        reset = 1'b0;
        tick();
        check("pulse_if_valid", {31'd0, if_valid}, 32'd0);
        check("pulse_occupancy", 32'(occupancy), 32'd0);
        check("pulse_req_valid", {31'd0, imem_req_valid}, 32'd0);
        reset = 1'b1;
        #1;
        check("restart_req_valid", {31'd0, imem_req_valid}, 32'd1);
        check("restart_req_addr", imem_req_addr, 32'h0);
        if_ready = 1'b1;
        expect_next(32'h0);
        expect_next(32'h4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, address and PC width.
REQ-002 The block SHALL have parameter RESET_VECTOR, default 0, the first fetch address after reset; word-aligned.
REQ-003 The block SHALL have parameter DEPTH, default 4, buffer entries; power of two, at least 2.
REQ-004 clk  in  1  the single clock; every register updates on its rising edge.
REQ-005 reset  in  1  reset; synchronous and active-low.
REQ-006 redirect_valid  in  1  branch/jump taken; restart fetch at redirect_pc.
REQ-007 redirect_pc  in  XLEN  new fetch address.
REQ-008 imem_req_valid  out  1  fetch request to instruction memory.
REQ-009 imem_req_addr  out  XLEN  fetch address.
REQ-010 imem_req_ready  in  1  memory accepts the request.
REQ-011 imem_rsp_valid  in  1  instruction word returned.
REQ-012 imem_rsp_data  in  32  returned instruction.
REQ-013 if_valid  out  1  head instruction available to decode.
REQ-014 if_pc  out  XLEN  PC of the head instruction.
REQ-015 if_instr  out  32  head instruction.
REQ-016 if_ready  in  1  decode consumes the head.
REQ-017 occupancy  out  clog2(DEPTH)+1  number of allocated buffer entries.

Function
REQ-018 A request SHALL be accepted when imem_req_valid and imem_req_ready are both high in the same cycle.
REQ-019 A response SHALL be delivered when imem_rsp_valid is high.
REQ-020 The block SHALL keep a fetch PC register; imem_req_addr SHALL equal the fetch PC.
REQ-021 The fetch PC SHALL advance by 4 on each accepted request, modulo 2^XLEN, wrapping silently.
REQ-022 imem_req_valid SHALL be high only when occupancy < DEPTH and redirect_valid is low.
REQ-023 Each accepted request SHALL allocate the tail entry of the circular buffer holding {pc, filled=0}.
REQ-024 Memory responses arrive in order, at least one cycle after acceptance; each non-discarded response SHALL write imem_rsp_data into the oldest unfilled entry and set filled=1.
REQ-025 if_valid SHALL be high only when the head entry is allocated and filled; if_pc and if_instr SHALL be driven from the head entry.
REQ-026 The head SHALL pop on the if_valid & if_ready handshake.
REQ-027 When pop and allocate occur in the same cycle, occupancy SHALL remain unchanged, including when the buffer is full.
REQ-028 A response may fill the head in the same cycle; if_valid SHALL rise on the following cycle, with no combinational bypass.
REQ-029 On redirect_valid, the next cycle SHALL satisfy all of:
  - fetch PC = {redirect_pc[XLEN-1:2], 2'b00};
  - all entries freed; occupancy = 0; if_valid = 0.
  Any pop or allocate in the redirect cycle SHALL be ignored.
REQ-030 Requests accepted but not yet answered at redirect SHALL be counted in a discard counter; that many subsequent responses SHALL be dropped without touching the buffer.
REQ-031 The discard counter SHALL never exceed DEPTH.
REQ-032 Requests SHALL resume the cycle after redirect; a new response in that window SHALL be dropped while the discard counter is nonzero.
REQ-033 Back-to-back redirects SHALL each take effect; the last one determines the fetch PC.
REQ-034 A response arriving with no unfilled entry and a zero discard counter is a protocol error; it SHALL be ignored.

Reset
REQ-035 While reset is low at a clock edge, the following SHALL hold:
  - fetch PC = RESET_VECTOR; occupancy = 0; discard counter = 0;
  - if_valid = 0; imem_req_valid = 0; if_pc = 0; if_instr = 0.
REQ-036 The first request SHALL be issued in the first cycle after reset deasserts.
REQ-037 Reset asserted mid-operation SHALL discard all entries and in-flight responses without producing any if_valid.

Verification
REQ-038 Reset, memory always ready with 1-cycle latency, if_ready=1 -> if_pc sequence 0x0, 0x4, 0x8, ...; one instruction per cycle after a 2-cycle fill.
REQ-039 if_ready=0 with DEPTH=4 -> exactly 4 requests (0x0 to 0xC), then imem_req_valid=0 and occupancy=4; raising if_ready for one cycle -> one pop and one new request to 0x10.
REQ-040 Redirect to 0x103 while 2 requests are in flight -> next request addr 0x100; the 2 stale responses are dropped; first if_pc = 0x100.
REQ-041 Fetch PC = 0xFFFFFFFC with XLEN=32 -> next request addr 0x0000_0000.
REQ-042 Memory ready toggling every other cycle with 3-cycle response latency -> in-order if_pc/if_instr, no loss or duplication over 100 instructions.
REQ-043 Reset pulsed low for one cycle with occupancy=3 -> if_valid=0 next cycle; fetch restarts at RESET_VECTOR.
